// File: rtl/golden_mon_pkg.sv
// Shared types and constants for the golden logic monitor.
package golden_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MONITOR = 2'd1,
    ALARM   = 2'd2
  } state_e;

  localparam int unsigned IDX_E = 0;
  localparam int unsigned IDX_F = 1;
  localparam int unsigned IDX_G = 2;
  localparam int unsigned IDX_H = 3;

endpackage

// File: rtl/golden_logic_ref.sv
// Combinational W-bit golden gate network: e, f, g, h evaluated bit-parallel.
module golden_logic_ref #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] e,
  output logic [W-1:0] f,
  output logic [W-1:0] g,
  output logic [W-1:0] h
);

  always_comb begin
    e = a & b;
    f = a | c;
    g = ~c;
    h = ((a & b) | ((a | c) & ~c)) & c;
  end

endmodule

// File: rtl/golden_logic_monitor.sv
// Two-stage golden-vs-suspect comparator with arm/monitor/alarm FSM and mismatch counter.
// Optional first-failure capture ports are enabled by defining GOLDEN_MON_FIRST_FAIL_EN.
module golden_logic_monitor
  import golden_mon_pkg::*;
#(
  parameter int unsigned W            = 8,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned ALARM_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               clear,
  input  logic               in_valid,
  input  logic [W-1:0]       a,
  input  logic [W-1:0]       b,
  input  logic [W-1:0]       c,
  input  logic [W-1:0]       dut_e,
  input  logic [W-1:0]       dut_f,
  input  logic [W-1:0]       dut_g,
  input  logic [W-1:0]       dut_h,
  output logic               ref_valid,
  output logic [W-1:0]       ref_e,
  output logic [W-1:0]       ref_f,
  output logic [W-1:0]       ref_g,
  output logic [W-1:0]       ref_h,
  output logic               mismatch,
  output logic [3:0]         mismatch_sel,
  output logic [CNT_W-1:0]   mismatch_cnt,
  output logic [1:0]         state,
  output logic               alarm
`ifdef GOLDEN_MON_FIRST_FAIL_EN
  ,
  output logic [3:0]         first_fail_sel,
  output logic [3*W-1:0]     first_fail_abc
`endif
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  // Stage 1: capture stimulus and suspect outputs
  logic         s1_valid;
  logic [W-1:0] s1_a, s1_b, s1_c;
  logic [W-1:0] s1_dut_e, s1_dut_f, s1_dut_g, s1_dut_h;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_c     <= '0;
      s1_dut_e <= '0;
      s1_dut_f <= '0;
      s1_dut_g <= '0;
      s1_dut_h <= '0;
    end else begin
      s1_valid <= in_valid & ~clear;
      s1_a     <= a;
      s1_b     <= b;
      s1_c     <= c;
      s1_dut_e <= dut_e;
      s1_dut_f <= dut_f;
      s1_dut_g <= dut_g;
      s1_dut_h <= dut_h;
    end
  end

  // Stage 2: golden evaluation and per-output compare
  logic [W-1:0] gold_e, gold_f, gold_g, gold_h;
  logic [3:0]   sel_d;
  logic         s2_valid_d;

  golden_logic_ref #(
    .W(W)
  ) u_ref (
    .a(s1_a),
    .b(s1_b),
    .c(s1_c),
    .e(gold_e),
    .f(gold_f),
    .g(gold_g),
    .h(gold_h)
  );

  always_comb begin
    s2_valid_d   = s1_valid & ~clear;
    sel_d        = '0;
    sel_d[IDX_E] = |(gold_e ^ s1_dut_e);
    sel_d[IDX_F] = |(gold_f ^ s1_dut_f);
    sel_d[IDX_G] = |(gold_g ^ s1_dut_g);
    sel_d[IDX_H] = |(gold_h ^ s1_dut_h);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_valid    <= 1'b0;
      ref_e        <= '0;
      ref_f        <= '0;
      ref_g        <= '0;
      ref_h        <= '0;
      mismatch     <= 1'b0;
      mismatch_sel <= '0;
    end else begin
      ref_valid    <= s2_valid_d;
      ref_e        <= gold_e;
      ref_f        <= gold_f;
      ref_g        <= gold_g;
      ref_h        <= gold_h;
      // Flags are zeroed for invalid slots so a stale compare never looks live
      mismatch     <= s2_valid_d & (|sel_d);
      mismatch_sel <= s2_valid_d ? sel_d : 4'b0000;
    end
  end

  // Control FSM and saturating counter
  state_e           state_q;
  logic             count_en;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    count_en = ref_valid & mismatch & ~clear & ((state_q == MONITOR) | (state_q == ALARM));
    cnt_inc  = (mismatch_cnt == CntMax) ? mismatch_cnt : mismatch_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      mismatch_cnt <= '0;
      alarm        <= 1'b0;
    end else if (clear) begin
      state_q      <= IDLE;
      mismatch_cnt <= '0;
      alarm        <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= MONITOR;
            mismatch_cnt <= '0;
          end
        end
        MONITOR: begin
          if (count_en) begin
            mismatch_cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(ALARM_THRESH)) begin
              state_q <= ALARM;
              alarm   <= 1'b1;
            end
          end
        end
        ALARM: begin
          alarm <= 1'b1;
          if (count_en) mismatch_cnt <= cnt_inc;
        end
        default: begin
          state_q <= IDLE;
          alarm   <= 1'b0;
        end
      endcase
    end
  end

  assign state = state_q;

`ifdef GOLDEN_MON_FIRST_FAIL_EN
  // Stimulus travels alongside stage 2 so a counted mismatch can be traced back
  logic [3*W-1:0] s2_abc;
  logic           ff_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_abc         <= '0;
      ff_done        <= 1'b0;
      first_fail_sel <= '0;
      first_fail_abc <= '0;
    end else begin
      s2_abc <= {s1_a, s1_b, s1_c};
      if (clear || (state_q == IDLE && start)) begin
        ff_done        <= 1'b0;
        first_fail_sel <= '0;
        first_fail_abc <= '0;
      end else if (count_en && !ff_done) begin
        ff_done        <= 1'b1;
        first_fail_sel <= mismatch_sel;
        first_fail_abc <= s2_abc;
      end
    end
  end
`endif

endmodule
